// File: rtl/adder_sweep_sequencer.sv
// Purpose : sweeps the instrumented adder ring through every masked sum bit and returns one ring count per bit.
// Latency : start -> CLEAR 1 cycle, LOAD 2, RUN 3..; done_in at RUN cycle k -> result_valid at k+2.
// Backpr. : result_valid holds in PRESENT with stable result_* until result_ready; the sweep stalls meanwhile.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start, abort                      begin a sweep (IDLE only) / cancel a sweep (any busy state)
//   sweep_mask, a_ring_bit,
//   integration_time                  sweep configuration, latched on start
//   done_in, count_in                 adder done / ring_osc_counter_out
//   adder_reset, counter_load,
//   counter_enable, stop_b            adder control (stop_b = 0 stops the ring)
//   s_output_bit_b, a_input_ring_bit_b active-low one-hot adder selects
//   result_count/bit/timeout/valid,
//   result_ready                      per-bit result, valid/ready handshake
//   busy, sweep_done                  status; sweep_done pulses once as busy falls
module adder_sweep_sequencer #(
  parameter int unsigned WATCHDOG_MARGIN = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  sweep_mask,
  input  logic [2:0]  a_ring_bit,
  input  logic [31:0] integration_time,
  input  logic        done_in,
  input  logic [31:0] count_in,
  output logic        adder_reset,
  output logic        counter_load,
  output logic        counter_enable,
  output logic        stop_b,
  output logic [7:0]  s_output_bit_b,
  output logic [7:0]  a_input_ring_bit_b,
  output logic [31:0] result_count,
  output logic [2:0]  result_bit,
  output logic        result_timeout,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_CAPTURE, S_PRESENT
  } state_t;

  state_t      state_q, state_nxt;
  logic [7:0]  mask_q, mask_nxt;
  logic [2:0]  ring_q, ring_nxt;
  logic [2:0]  idx_q, idx_nxt;
  logic [31:0] itime_q, itime_nxt;
  logic [32:0] wd_q, wd_nxt;
  logic        to_q, to_nxt;
  logic        done_pulse_nxt;
  logic [7:0]  mask_left;
  logic [32:0] wd_limit;

  // 33-bit sum so a maximal integration time cannot wrap the limit.
  assign wd_limit  = {1'b0, itime_q} + 33'(WATCHDOG_MARGIN);
  assign mask_left = mask_q & ~(8'b1 << idx_q);

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  always_comb begin
    state_nxt      = state_q;
    mask_nxt       = mask_q;
    ring_nxt       = ring_q;
    idx_nxt        = idx_q;
    itime_nxt      = itime_q;
    wd_nxt         = wd_q;
    to_nxt         = to_q;
    done_pulse_nxt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_nxt  = sweep_mask;
          ring_nxt  = a_ring_bit;
          itime_nxt = integration_time;
          if (sweep_mask == 8'd0) begin
            done_pulse_nxt = 1'b1;
          end else begin
            idx_nxt   = lowest_bit(sweep_mask);
            state_nxt = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD: begin
        // The watchdog holds the number of RUN cycles including the current one.
        wd_nxt    = 33'd1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (done_in) begin
          to_nxt    = 1'b0;
          state_nxt = S_CAPTURE;
        end else if (wd_q >= wd_limit) begin
          // >= rather than == keeps a zero limit from running forever.
          to_nxt    = 1'b1;
          state_nxt = S_CAPTURE;
        end else begin
          wd_nxt = wd_q + 33'd1;
        end
      end
      S_CAPTURE: state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (result_ready) begin
          mask_nxt = mask_left;
          if (mask_left != 8'd0) begin
            idx_nxt   = lowest_bit(mask_left);
            state_nxt = S_CLEAR;
          end else begin
            done_pulse_nxt = 1'b1;
            state_nxt      = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_nxt      = S_IDLE;
      done_pulse_nxt = 1'b0;
    end
  end

  // Outputs are registered from the next state so each one lines up with the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      mask_q             <= 8'd0;
      ring_q             <= 3'd0;
      idx_q              <= 3'd0;
      itime_q            <= 32'd0;
      wd_q               <= 33'd0;
      to_q               <= 1'b0;
      adder_reset        <= 1'b0;
      counter_load       <= 1'b0;
      counter_enable     <= 1'b0;
      stop_b             <= 1'b0;
      s_output_bit_b     <= 8'hFF;
      a_input_ring_bit_b <= 8'hFF;
      result_count       <= 32'd0;
      result_bit         <= 3'd0;
      result_timeout     <= 1'b0;
      result_valid       <= 1'b0;
      busy               <= 1'b0;
      sweep_done         <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      mask_q         <= mask_nxt;
      ring_q         <= ring_nxt;
      idx_q          <= idx_nxt;
      itime_q        <= itime_nxt;
      wd_q           <= wd_nxt;
      to_q           <= to_nxt;
      adder_reset    <= (state_nxt == S_CLEAR);
      counter_load   <= (state_nxt == S_LOAD);
      counter_enable <= (state_nxt == S_RUN);
      stop_b         <= (state_nxt == S_RUN);
      result_valid   <= (state_nxt == S_PRESENT);
      busy           <= (state_nxt != S_IDLE);
      sweep_done     <= done_pulse_nxt;
      if (state_nxt == S_CLEAR || state_nxt == S_LOAD ||
          state_nxt == S_RUN || state_nxt == S_CAPTURE) begin
        s_output_bit_b     <= ~(8'b1 << idx_nxt);
        a_input_ring_bit_b <= ~(8'b1 << ring_nxt);
      end else begin
        s_output_bit_b     <= 8'hFF;
        a_input_ring_bit_b <= 8'hFF;
      end
      // An abort during CAPTURE discards the sample, leaving the previous result intact.
      if (state_q == S_CAPTURE && state_nxt == S_PRESENT) begin
        result_count   <= count_in;
        result_bit     <= idx_q;
        result_timeout <= to_q;
      end
    end
  end

endmodule

// File: tb/tb_adder_sweep_sequencer.sv
module tb_adder_sweep_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  sweep_mask;
  logic [2:0]  a_ring_bit;
  logic [31:0] integration_time;
  logic        done_in;
  logic [31:0] count_in;
  logic        adder_reset, counter_load, counter_enable, stop_b;
  logic [7:0]  s_output_bit_b, a_input_ring_bit_b;
  logic [31:0] result_count;
  logic [2:0]  result_bit;
  logic        result_timeout, result_valid, result_ready;
  logic        busy, sweep_done;

  always #5 clk = ~clk;

  adder_sweep_sequencer #(.WATCHDOG_MARGIN(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .sweep_mask(sweep_mask), .a_ring_bit(a_ring_bit), .integration_time(integration_time),
    .done_in(done_in), .count_in(count_in),
    .adder_reset(adder_reset), .counter_load(counter_load), .counter_enable(counter_enable),
    .stop_b(stop_b), .s_output_bit_b(s_output_bit_b), .a_input_ring_bit_b(a_input_ring_bit_b),
    .result_count(result_count), .result_bit(result_bit), .result_timeout(result_timeout),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .sweep_done(sweep_done)
  );

  // Adder model: done_in rises done_at cycles into RUN (0 = never);
  // the count is a per-sweep base with the selected sum bit in bits 22:20.
  logic [31:0] rc, done_at, base;
  logic [2:0]  sel_idx;
  always @(posedge clk) rc <= counter_enable ? rc + 32'd1 : 32'd0;
  assign done_in = counter_enable && (done_at != 32'd0) && (rc + 32'd1 == done_at);
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) if (!s_output_bit_b[i]) sel_idx = 3'(i);
    count_in = base + ({29'd0, sel_idx} << 20);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [2:0]  ring;
    logic [31:0] itime;
    logic [31:0] done_at;
    logic [31:0] base;
    int          rw;
    int          exp_run;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic start_sweep(input vec_t v);
    @(negedge clk);
    sweep_mask       = v.mask;
    a_ring_bit       = v.ring;
    integration_time = v.itime;
    done_at          = v.done_at;
    base             = v.base;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge right after the edge that should produce CLEAR.
  task automatic run_bit(input int b, input logic [2:0] ring, input logic [31:0] bs,
                         input int rw, input int exp_run, input logic exp_to);
    logic [7:0]  ssel, asel;
    logic [31:0] cnt_exp;
    int          runlen;
    logic        bad;
    ssel    = ~(8'b1 << b);
    asel    = ~(8'b1 << ring);
    cnt_exp = bs + (32'(b) << 20);
    chk("clear_ctl", 64'({adder_reset, stop_b, counter_load, counter_enable}), 64'(4'b1000));
    chk("clear_ssel", 64'(s_output_bit_b), 64'(ssel));
    chk("clear_asel", 64'(a_input_ring_bit_b), 64'(asel));
    @(negedge clk);
    chk("load_ctl", 64'({adder_reset, stop_b, counter_load, counter_enable}), 64'(4'b0010));
    runlen = 0;
    bad    = 1'b0;
    @(negedge clk);
    while (counter_enable && runlen < 400) begin
      if (stop_b !== 1'b1 || s_output_bit_b !== ssel || a_input_ring_bit_b !== asel ||
          result_valid !== 1'b0) bad = 1'b1;
      runlen++;
      @(negedge clk);
    end
    chk("run_len", 64'(runlen), 64'(exp_run));
    chk("run_drive", 64'(bad), 64'd0);
    chk("capture_ctl", 64'({stop_b, counter_enable, result_valid}), 64'd0);
    chk("capture_ssel", 64'(s_output_bit_b), 64'(ssel));
    @(negedge clk);
    chk("valid", 64'(result_valid), 64'd1);
    chk("res_count", 64'(result_count), 64'(cnt_exp));
    chk("res_bit", 64'(result_bit), 64'(b));
    chk("res_timeout", 64'(result_timeout), 64'(exp_to));
    chk("present_sel", 64'({s_output_bit_b, a_input_ring_bit_b}), 64'hFFFF);
    bad = 1'b0;
    repeat (rw) begin
      @(negedge clk);
      if (result_valid !== 1'b1 || result_count !== cnt_exp || result_bit !== 3'(b) ||
          result_timeout !== exp_to) bad = 1'b1;
    end
    if (rw > 0) chk("hold_stable", 64'(bad), 64'd0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic do_sweep(input vec_t v);
    start_sweep(v);
    for (int b = 0; b < 8; b++)
      if (v.mask[b]) run_bit(b, v.ring, v.base, v.rw, v.exp_run, v.exp_to);
    chk("sweep_done", 64'({sweep_done, busy, result_valid}), 64'(3'b100));
    @(negedge clk);
    chk("sweep_done_1cyc", 64'({sweep_done, busy}), 64'd0);
  endtask

  initial begin
    logic bad;
    vec_t va;
    //          mask   ring  itime   done_at base           rw run to
    vecs[0] = '{8'h04, 3'd1, 32'd10, 32'd10, 32'h0000_0123, 0, 10, 1'b0};
    vecs[1] = '{8'h81, 3'd5, 32'd30, 32'd7,  32'h000A_BCD0, 5, 7,  1'b0};
    vecs[2] = '{8'h00, 3'd0, 32'd10, 32'd3,  32'h0000_0001, 0, 0,  1'b0};
    vecs[3] = '{8'h10, 3'd7, 32'd20, 32'd0,  32'h0000_7777, 0, 36, 1'b1};
    vecs[4] = '{8'h40, 3'd2, 32'd4,  32'd20, 32'h0000_0042, 1, 20, 1'b0};
    vecs[5] = '{8'h2A, 3'd0, 32'd3,  32'd50, 32'h0100_0000, 2, 19, 1'b1};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    sweep_mask = 8'd0; a_ring_bit = 3'd0; integration_time = 32'd0;
    done_at = 32'd0; base = 32'd0;
    #12;
    chk("reset_ctl", 64'({adder_reset, counter_load, counter_enable, stop_b, result_valid, busy, sweep_done}), 64'd0);
    chk("reset_sel", 64'({s_output_bit_b, a_input_ring_bit_b}), 64'hFFFF);
    chk("reset_result", 64'({result_count, result_bit, result_timeout}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) do_sweep(vecs[i]);

    // Abort during RUN of the second bit of mask 8'h03.
    va = '{8'h03, 3'd2, 32'd40, 32'd5, 32'h0000_0500, 0, 5, 1'b0};
    start_sweep(va);
    run_bit(0, va.ring, va.base, 0, 5, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_in_run", 64'(counter_enable), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 64'({busy, stop_b, counter_enable, adder_reset, counter_load, result_valid, sweep_done}), 64'd0);
    chk("abort_sel", 64'({s_output_bit_b, a_input_ring_bit_b}), 64'hFFFF);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (result_valid || sweep_done || busy) bad = 1'b1;
    end
    chk("abort_quiet", 64'(bad), 64'd0);

    // Asynchronous reset in the middle of RUN, then a normal sweep.
    va = '{8'h01, 3'd3, 32'd40, 32'd0, 32'h0000_0900, 0, 56, 1'b1};
    start_sweep(va);
    repeat (4) @(negedge clk);
    chk("reset_pre_run", 64'(counter_enable), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_ctl", 64'({adder_reset, counter_load, counter_enable, stop_b, result_valid, busy, sweep_done}), 64'd0);
    chk("areset_sel", 64'({s_output_bit_b, a_input_ring_bit_b}), 64'hFFFF);
    chk("areset_result", 64'({result_count, result_bit, result_timeout}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_sweep(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
